sap_ext_mem_bridge: RTL and testbench

Sits directly downstream of the SAP-3 core's memory-control outputs: takes the core's 16-bit bus, MAR write strobe and RAM write strobe, and runs read/write transactions against an external byte-wide SRAM over the chip's 8-bit bidirectional IO pins. It replaces direct pin exposure of the raw bus with a multiplexed address/data protocol, a handshake with timeout, and returns read data plus a ready pulse to the core's memory input.

---
 rtl/sap3_mem_pkg.sv | 17 +
 rtl/sap_bus_timer.sv | 31 +++
 rtl/sap_ext_mem_bridge.sv | 169 ++++++++++++++++
 tb/tb_sap_ext_mem_bridge.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap3_mem_pkg.sv
// Shared types and constants for the SAP-3 external memory bridge.
package sap3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    WR,
    RD,
    DONE
  } state_t;

  localparam logic [7:0] OE_DRIVE          = 8'hFF;
  localparam logic [7:0] OE_FLOAT          = 8'h00;
  localparam logic [7:0] READ_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/sap_bus_timer.sv
// Data-phase watchdog: counts cycles spent waiting for the external ack.
// tc is high during the cycle whose increment would reach TIMEOUT, so a
// data phase lasts at most TIMEOUT cycles before it is abandoned.
module sap_bus_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  // Cycle counter, cleared on entry to a data phase.
  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/sap_ext_mem_bridge.sv
// Bridges the SAP-3 core memory strobes to a byte-wide external SRAM over a
// multiplexed 8-bit pin bus: high address, low address, then a data phase
// with ack handshake and timeout. The high address byte is skipped when it
// matches the last one sent since reset.
module sap_ext_mem_bridge
  import sap3_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic              mar_we,
  input  logic              ram_we,
  input  logic              rd_req,
  input  logic              clr_err,
  output logic [7:0]        mem_data,
  output logic              mem_ready,
  output logic              busy,
  output logic              err,
  output logic [7:0]        ext_out,
  output logic [7:0]        ext_oe,
  input  logic [7:0]        ext_in,
  output logic              ext_ale_hi,
  output logic              ext_ale_lo,
  output logic              ext_wr,
  output logic              ext_rd,
  input  logic              ext_ack
);

  localparam int HI_LSB = ADDR_W - 8;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] txn_addr;
  logic [ADDR_W-1:0] fwd_addr;
  logic [7:0]        wdata;
  logic [7:0]        last_hi;
  logic              hi_valid;
  logic              is_write;
  logic              in_data;
  logic              timer_tc;
  logic              timeout_hit;

  // A request accepted in the same cycle as a MAR load uses the new address.
  assign fwd_addr    = mar_we ? bus_in : mar;
  assign in_data     = (state == WR) || (state == RD);
  // Ack wins over a coincident timeout.
  assign timeout_hit = in_data && timer_tc && !ext_ack;

  sap_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk(CLK),
    .rst(rst),
    .clr(state == ADDR_LO),
    .en (in_data),
    .tc (timer_tc)
  );

  // MAR loads whenever the core strobes it, independent of bridge state.
  // NOTE: the asynchronous reset is in the sensitivity list so pins and
  // state drop the moment rst rises, not at the next clock edge.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mar <= '0;
    end else if (mar_we) begin
      mar <= bus_in;
    end
  end

  // Sticky timeout flag; a same-cycle timeout beats clr_err.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

  // Transaction FSM; all pin and core-side outputs are registered here.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      txn_addr   <= '0;
      wdata      <= '0;
      last_hi    <= '0;
      hi_valid   <= 1'b0;
      is_write   <= 1'b0;
      mem_data   <= 8'h00;
      mem_ready  <= 1'b0;
      busy       <= 1'b0;
      ext_out    <= '0;
      ext_oe     <= OE_FLOAT;
      ext_ale_hi <= 1'b0;
      ext_ale_lo <= 1'b0;
      ext_wr     <= 1'b0;
      ext_rd     <= 1'b0;
    end else begin
      // NOTE: mem_ready defaults low every cycle so it is a single-cycle
      // pulse; only the edge entering DONE raises it.
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ram_we || rd_req) begin
            txn_addr <= fwd_addr;
            wdata    <= bus_in[7:0];
            is_write <= ram_we;
            busy     <= 1'b1;
            ext_oe   <= OE_DRIVE;
            if (hi_valid && (fwd_addr[ADDR_W-1:HI_LSB] == last_hi)) begin
              state      <= ADDR_LO;
              ext_out    <= fwd_addr[7:0];
              ext_ale_lo <= 1'b1;
            end else begin
              state      <= ADDR_HI;
              ext_out    <= fwd_addr[ADDR_W-1:HI_LSB];
              ext_ale_hi <= 1'b1;
              last_hi    <= fwd_addr[ADDR_W-1:HI_LSB];
              hi_valid   <= 1'b1;
            end
          end
        end
        ADDR_HI: begin
          state      <= ADDR_LO;
          ext_out    <= txn_addr[7:0];
          ext_ale_hi <= 1'b0;
          ext_ale_lo <= 1'b1;
        end
        ADDR_LO: begin
          ext_ale_lo <= 1'b0;
          if (is_write) begin
            state   <= WR;
            ext_out <= wdata;
            ext_wr  <= 1'b1;
          end else begin
            state  <= RD;
            ext_oe <= OE_FLOAT;
            ext_rd <= 1'b1;
          end
        end
        WR, RD: begin
          if (ext_ack || timer_tc) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            ext_oe    <= OE_FLOAT;
            ext_wr    <= 1'b0;
            ext_rd    <= 1'b0;
            if (state == RD) begin
              mem_data <= ext_ack ? ext_in : READ_TIMEOUT_DATA;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap_ext_mem_bridge.sv
// Scoreboard bench for sap_ext_mem_bridge: a driver issues transactions and
// pushes expectations from a transaction-level model, an SRAM responder
// plays the external device, and a monitor checks each mem_ready.
module tb_sap_ext_mem_bridge;

  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_in = '0;
  logic        mar_we = 1'b0;
  logic        ram_we = 1'b0;
  logic        rd_req = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        busy;
  logic        err;
  logic [7:0]  ext_out;
  logic [7:0]  ext_oe;
  logic [7:0]  ext_in = '0;
  logic        ext_ale_hi;
  logic        ext_ale_lo;
  logic        ext_wr;
  logic        ext_rd;
  logic        ext_ack = 1'b0;

  sap_ext_mem_bridge #(.ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .rst(rst), .bus_in(bus_in), .mar_we(mar_we), .ram_we(ram_we),
    .rd_req(rd_req), .clr_err(clr_err), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .err(err), .ext_out(ext_out),
    .ext_oe(ext_oe), .ext_in(ext_in), .ext_ale_hi(ext_ale_hi),
    .ext_ale_lo(ext_ale_lo), .ext_wr(ext_wr), .ext_rd(ext_rd),
    .ext_ack(ext_ack)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          hi_sent;
    logic [7:0]  rdata;
    bit          err;
    int          lat;
    int          dcyc;
    int          accept;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: what the SRAM should hold and what the bridge remembers.
  logic [7:0] ref_mem[int];
  logic [7:0] dev_mem[int];
  bit         hv_m = 1'b0;
  logic [7:0] last_hi_m = '0;
  bit         err_m = 1'b0;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a ^ (a >> 8) ^ 8'h3C);
  endfunction

  // External SRAM: latches the multiplexed address, acks after ack_delay data cycles.
  int         ack_delay = 0;
  int         dcnt = 0;
  logic [7:0] dev_hi = '0;
  logic [7:0] dev_lo = '0;
  always @(negedge CLK) begin
    if (rst) begin
      dcnt = 0;
      ext_ack = 1'b0;
    end else begin
      if (ext_ale_hi) dev_hi = ext_out;
      if (ext_ale_lo) dev_lo = ext_out;
      if (ext_rd || ext_wr) begin
        if (dcnt == ack_delay) begin
          ext_ack = 1'b1;
          if (ext_rd) ext_in = dev_mem.exists(int'({dev_hi, dev_lo})) ?
                               dev_mem[int'({dev_hi, dev_lo})] : init_val(int'({dev_hi, dev_lo}));
          else        dev_mem[int'({dev_hi, dev_lo})] = ext_out;
        end else begin
          ext_ack = 1'b0;
          ext_in  = 8'($urandom);
        end
        dcnt++;
      end else begin
        dcnt    = 0;
        ext_ack = 1'($urandom);
        ext_in  = 8'($urandom);
      end
    end
  end

  // Monitor: collects pin activity per transaction, scores it at mem_ready.
  bit         o_hi_seen;
  logic [7:0] o_hi, o_lo, o_wr;
  int         o_wcyc, o_rcyc;
  bit         o_bad_oe;
  exp_t       m_e;

  task automatic clear_obs();
    o_hi_seen = 1'b0; o_hi = 'x; o_lo = 'x; o_wr = 'x;
    o_wcyc = 0; o_rcyc = 0; o_bad_oe = 1'b0;
  endtask

  initial clear_obs();

  always @(negedge CLK) begin
    if (rst) begin
      clear_obs();
    end else begin
      if (ext_ale_hi) begin o_hi_seen = 1'b1; o_hi = ext_out; if (ext_oe != 8'hFF) o_bad_oe = 1'b1; end
      if (ext_ale_lo) begin o_lo = ext_out; if (ext_oe != 8'hFF) o_bad_oe = 1'b1; end
      if (ext_wr) begin o_wr = ext_out; o_wcyc++; if (ext_oe != 8'hFF) o_bad_oe = 1'b1; end
      if (ext_rd) begin o_rcyc++; if (ext_oe != 8'h00) o_bad_oe = 1'b1; end
      if (mem_ready) begin
        check("ready_has_pending_txn", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("hi_phase_sent", 32'(o_hi_seen), 32'(m_e.hi_sent));
          if (m_e.hi_sent) check("ale_hi_byte", 32'(o_hi), 32'(m_e.addr[15:8]));
          check("ale_lo_byte", 32'(o_lo), 32'(m_e.addr[7:0]));
          check("wr_cycles", 32'(o_wcyc), 32'(m_e.is_wr ? m_e.dcyc : 0));
          check("rd_cycles", 32'(o_rcyc), 32'(m_e.is_wr ? 0 : m_e.dcyc));
          if (m_e.is_wr) check("wr_data", 32'(o_wr), 32'(m_e.wdata));
          else           check("mem_data", 32'(mem_data), 32'(m_e.rdata));
          check("err_flag", 32'(err), 32'(m_e.err));
          check("latency", 32'(cyc - m_e.accept + 1), 32'(m_e.lat));
          check("oe_during_phases", 32'(o_bad_oe), 32'd0);
          check("done_pins_idle", 32'({ext_oe, ext_rd, ext_wr, ext_ale_hi, ext_ale_lo}), 32'd0);
        end
        clear_obs();
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, 32'({mem_data, mem_ready, busy, err, ext_out, ext_oe,
                     ext_ale_hi, ext_ale_lo, ext_wr, ext_rd}), 32'd0);
  endtask

  // Issue one transaction, push its expectation, wait (bounded) for completion.
  task automatic do_txn(input bit is_wr, input logic [15:0] addr, input logic [7:0] data,
                        input int delay, input bit fwd, input bit both, input bit poke,
                        input bit hold_clr);
    exp_t e;
    bit   skip;
    bit   to;
    int   w;
    if (!fwd) begin
      @(negedge CLK); mar_we = 1'b1; bus_in = addr;
    end
    @(negedge CLK);
    ack_delay = delay;
    mar_we  = fwd;
    bus_in  = fwd ? addr : (is_wr ? {8'($urandom), data} : 16'($urandom));
    ram_we  = is_wr;
    rd_req  = !is_wr || both;
    clr_err = hold_clr;
    skip      = hv_m && (last_hi_m == addr[15:8]);
    hv_m      = 1'b1;
    last_hi_m = addr[15:8];
    to        = (delay < 0);
    e.is_wr   = is_wr;
    e.addr    = addr;
    e.wdata   = fwd ? addr[7:0] : data;
    e.hi_sent = !skip;
    e.dcyc    = to ? TIMEOUT : delay + 1;
    e.lat     = (skip ? 2 : 3) + e.dcyc;
    e.rdata   = to ? 8'hFF : (ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : init_val(int'(addr)));
    if (is_wr && !to) ref_mem[int'(addr)] = e.wdata;
    err_m     = to ? 1'b1 : (hold_clr ? 1'b0 : err_m);
    e.err     = err_m;
    e.accept  = cyc + 1;
    exp_q.push_back(e);
    @(negedge CLK);
    mar_we = 1'b0; ram_we = 1'b0; rd_req = 1'b0;
    if (poke) begin
      rd_req = 1'b1; ram_we = 1'($urandom); mar_we = 1'($urandom); bus_in = 16'($urandom);
      @(negedge CLK);
      rd_req = 1'b0; ram_we = 1'b0; mar_we = 1'b0;
    end
    w = 0;
    while (!mem_ready && w < 200) begin @(negedge CLK); w++; end
    check("txn_completes", 32'(mem_ready), 32'd1);
    clr_err = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_clr();
    @(negedge CLK); clr_err = 1'b1;
    @(negedge CLK); clr_err = 1'b0;
    err_m = 1'b0;
    check("err_cleared", 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] his[4];
    his[0] = 8'h12; his[1] = 8'h34; his[2] = 8'h80; his[3] = 8'h00;
    ref_mem[int'(16'h1234)] = 8'hA5;
    dev_mem[int'(16'h1234)] = 8'hA5;

    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_values_initial");
    rst = 1'b0;

    // Reset in the middle of a read data phase.
    ack_delay = -1;
    @(negedge CLK); mar_we = 1'b1; bus_in = 16'h1234;
    @(negedge CLK); mar_we = 1'b0; rd_req = 1'b1; bus_in = 16'($urandom);
    @(negedge CLK); rd_req = 1'b0;
    w = 0;
    while (!ext_rd && w < 10) begin @(negedge CLK); w++; end
    check("rd_strobe_before_reset", 32'(ext_rd), 32'd1);
    @(negedge CLK);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_values_mid_read");
    hv_m = 1'b0; err_m = 1'b0;
    @(negedge CLK); @(negedge CLK);
    rst = 1'b0;

    // Directed sequence.
    do_txn(1'b0, 16'h1234, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_txn(1'b1, 16'h1235, 8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_txn(1'b0, 16'h1236, 8'h00, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_clr();
    do_txn(1'b1, 16'h2000, 8'h77, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    do_txn(1'b0, 16'h2000, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    do_txn(1'b0, 16'h8000, 8'h00, TIMEOUT - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_txn(1'b0, 16'h1235, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_txn(1'b0, 16'h8001, 8'h00, -1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic over a few high bytes so the skip path is exercised.
    for (int i = 0; i < 60; i++) begin
      bit          wr;
      logic [15:0] a;
      int          r, d;
      wr = 1'($urandom);
      a  = {his[$urandom_range(0, 3)], 8'($urandom)};
      r  = $urandom_range(0, 9);
      d  = (r == 0) ? -1 : ((r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4));
      do_txn(wr, a, 8'($urandom), d, !wr && 1'($urandom), wr && ($urandom_range(0, 3) == 0),
             1'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) do_clr();
    end

    repeat (5) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
